// File: rtl/mem_wb_multi.sv
// MEM/WB pipeline register for a multi-lane issue core: captures per-lane MEM
// results, suppresses redundant register writes, and counts retired instructions and bubbles.
module mem_wb_multi #(
  parameter int LANES   = 2,
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stop,
  input  logic                  flush,
  input  logic [LANES-1:0]      mem_valid,
  input  logic [LANES*AW-1:0]   mem_wd,
  input  logic [LANES-1:0]      mem_wreg,
  input  logic [LANES*DW-1:0]   mem_wdata,
  input  logic                  mem_whilo,
  input  logic [DW-1:0]         mem_hi,
  input  logic [DW-1:0]         mem_lo,
  output logic [LANES-1:0]      wb_valid,
  output logic [LANES*AW-1:0]   wb_wd,
  output logic [LANES-1:0]      wb_wreg,
  output logic [LANES*DW-1:0]   wb_wdata,
  output logic                  wb_whilo,
  output logic [DW-1:0]         wb_hi,
  output logic [DW-1:0]         wb_lo,
  output logic [31:0]           retire_cnt,
  output logic [15:0]           bubble_cnt
);

  localparam int CW = $clog2(LANES + 1);

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD
  } action_e;

  action_e           action;
  logic [LANES-1:0]  wreg_eff;
  logic [CW-1:0]     lane_count;
  logic              any_valid;

  // Only this stage's bit and the downstream bit matter here.
  logic stop_unused;
  assign stop_unused = ^stop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    action = ACT_HOLD;
    if (rst)
      action = ACT_RESET;
    else if (flush)
      action = ACT_FLUSH;
    else if (stop[STAGE] && !stop[STAGE+1])
      action = ACT_BUBBLE;
    else if (!stop[STAGE])
      action = ACT_ADVANCE;
  end

  // A lane writes only if valid, enabled, not targeting r0, and no younger lane
  // writes the same register in this group.
  always_comb begin
    wreg_eff = '0;
    for (int i = 0; i < LANES; i++) begin
      wreg_eff[i] = mem_valid[i] && mem_wreg[i] && (mem_wd[i*AW +: AW] != '0);
      for (int j = 0; j < LANES; j++) begin
        if (j > i && mem_valid[j] && mem_wreg[j] &&
            (mem_wd[j*AW +: AW] == mem_wd[i*AW +: AW]))
          wreg_eff[i] = 1'b0;
      end
    end
  end

  always_comb begin
    lane_count = '0;
    for (int i = 0; i < LANES; i++)
      lane_count = lane_count + CW'(mem_valid[i]);
    any_valid = |mem_valid;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    case (action)
      ACT_RESET: begin
        wb_valid   <= '0;
        wb_wd      <= '0;
        wb_wreg    <= '0;
        wb_wdata   <= '0;
        wb_whilo   <= 1'b0;
        wb_hi      <= '0;
        wb_lo      <= '0;
        retire_cnt <= '0;
        bubble_cnt <= '0;
      end
      ACT_FLUSH, ACT_BUBBLE: begin
        wb_valid <= '0;
        wb_wd    <= '0;
        wb_wreg  <= '0;
        wb_wdata <= '0;
        wb_whilo <= 1'b0;
        wb_hi    <= '0;
        wb_lo    <= '0;
        // Flushes are not bubbles; the bubble count saturates rather than wraps.
        if (action == ACT_BUBBLE && bubble_cnt != 16'hFFFF)
          bubble_cnt <= bubble_cnt + 16'd1;
      end
      ACT_ADVANCE: begin
        wb_valid   <= mem_valid;
        wb_wd      <= mem_wd;
        wb_wreg    <= wreg_eff;
        wb_wdata   <= mem_wdata;
        wb_whilo   <= mem_whilo && any_valid;
        wb_hi      <= mem_hi;
        wb_lo      <= mem_lo;
        retire_cnt <= retire_cnt + 32'(lane_count);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_multi.sv
// Scoreboard bench for mem_wb_multi: a behavioural model predicts the registered
// state after each edge and a monitor compares it against the DUT.
module tb_mem_wb_multi;

  localparam int LANES   = 2;
  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int STALL_W = 6;
  localparam int STAGE   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [STALL_W-1:0]  stop;
  logic                flush;
  logic [LANES-1:0]    mem_valid;
  logic [LANES*AW-1:0] mem_wd;
  logic [LANES-1:0]    mem_wreg;
  logic [LANES*DW-1:0] mem_wdata;
  logic                mem_whilo;
  logic [DW-1:0]       mem_hi;
  logic [DW-1:0]       mem_lo;
  logic [LANES-1:0]    wb_valid;
  logic [LANES*AW-1:0] wb_wd;
  logic [LANES-1:0]    wb_wreg;
  logic [LANES*DW-1:0] wb_wdata;
  logic                wb_whilo;
  logic [DW-1:0]       wb_hi;
  logic [DW-1:0]       wb_lo;
  logic [31:0]         retire_cnt;
  logic [15:0]         bubble_cnt;

  mem_wb_multi #(.LANES(LANES), .DW(DW), .AW(AW), .STALL_W(STALL_W), .STAGE(STAGE)) dut (
    .clk(clk), .rst(rst), .stop(stop), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0]    valid;
    logic [LANES*AW-1:0] wd;
    logic [LANES-1:0]    wreg;
    logic [LANES*DW-1:0] wdata;
    logic                whilo;
    logic [DW-1:0]       hi;
    logic [DW-1:0]       lo;
    logic [31:0]         retire;
    logic [15:0]         bubble;
  } exp_t;

  exp_t model;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t cleared(input exp_t s);
    exp_t n;
    n = s;
    n.valid = '0; n.wd = '0; n.wreg = '0; n.wdata = '0;
    n.whilo = 1'b0; n.hi = '0; n.lo = '0;
    return n;
  endfunction

  // Reference: state after the next edge, derived from the action rules.
  function automatic exp_t model_next(input exp_t s);
    exp_t n;
    logic [(1<<AW)-1:0] claimed;
    logic [AW-1:0] r;
    n = s;
    if (rst) begin
      n = cleared(s);
      n.retire = 0;
      n.bubble = 0;
    end else if (flush) begin
      n = cleared(s);
    end else if (stop[STAGE] && !stop[STAGE+1]) begin
      n = cleared(s);
      if (s.bubble != 16'hFFFF) n.bubble = s.bubble + 16'd1;
    end else if (!stop[STAGE]) begin
      n.valid = mem_valid;
      n.wd    = mem_wd;
      n.wdata = mem_wdata;
      n.hi    = mem_hi;
      n.lo    = mem_lo;
      n.whilo = mem_whilo && (mem_valid != 0);
      claimed = '0;
      // Walk youngest to oldest; the first lane to claim a register keeps it.
      for (int i = LANES - 1; i >= 0; i--) begin
        r = mem_wd[i*AW +: AW];
        n.wreg[i] = 1'b0;
        if (mem_valid[i] && mem_wreg[i] && r != 0) begin
          if (!claimed[r]) n.wreg[i] = 1'b1;
          claimed[r] = 1'b1;
        end
      end
      n.retire = s.retire + 32'($countones(mem_valid));
    end
    return n;
  endfunction

  // Inputs are set just after a negedge; predict, enqueue, and wait for the next negedge.
  task automatic tick();
    model = model_next(model);
    sb_q.push_back(model);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; stop = '0; flush = 1'b0;
    mem_valid = '0; mem_wd = '0; mem_wreg = '0; mem_wdata = '0;
    mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
  endtask

  task automatic randomize_mem();
    mem_valid = LANES'($urandom);
    mem_wreg  = LANES'($urandom);
    for (int i = 0; i < LANES; i++) begin
      mem_wd[i*AW +: AW]    = AW'($urandom_range(0, 7));
      mem_wdata[i*DW +: DW] = $urandom;
    end
    mem_whilo = 1'($urandom);
    mem_hi    = $urandom;
    mem_lo    = $urandom;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_valid",   64'(wb_valid),   64'(e.valid));
        check("wb_wd",      64'(wb_wd),      64'(e.wd));
        check("wb_wreg",    64'(wb_wreg),    64'(e.wreg));
        check("wb_wdata",   64'(wb_wdata),   64'(e.wdata));
        check("wb_whilo",   64'(wb_whilo),   64'(e.whilo));
        check("wb_hi",      64'(wb_hi),      64'(e.hi));
        check("wb_lo",      64'(wb_lo),      64'(e.lo));
        check("retire_cnt", 64'(retire_cnt), 64'(e.retire));
        check("bubble_cnt", 64'(bubble_cnt), 64'(e.bubble));
      end
    end
  end

  initial begin : driver
    int guard;
    model = '{default: '0};
    idle();
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Two-lane advance
    stop = '0; mem_valid = 2'b11; mem_wd = {5'd3, 5'd4}; mem_wreg = 2'b11;
    mem_wdata = {32'hA, 32'hB};
    tick();

    // Bubble, then hold with changing inputs
    stop = 6'b010000; tick();
    stop = 6'b110000;
    for (int k = 0; k < 3; k++) begin randomize_mem(); tick(); end

    // Advance real data, then hold it for 3 cycles
    idle(); randomize_mem(); mem_valid = 2'b11; tick();
    stop = 6'b110000;
    for (int k = 0; k < 3; k++) begin randomize_mem(); tick(); end

    // Duplicate destination: youngest lane wins
    idle(); mem_valid = 2'b11; mem_wreg = 2'b11; mem_wd = {5'd7, 5'd7};
    mem_wdata = {32'h22, 32'h11};
    tick();

    // r0 on lane0, invalid lane1
    idle(); mem_valid = 2'b01; mem_wreg = 2'b11; mem_wd = {5'd9, 5'd0};
    mem_wdata = {32'h33, 32'h44};
    tick();

    // HI/LO advance, then flush with stall and HI/LO request
    idle(); mem_valid = 2'b10; mem_whilo = 1'b1; mem_hi = 32'h1234; mem_lo = 32'h5678; tick();
    flush = 1'b1; stop = 6'b010000; tick();
    flush = 1'b1; stop = 6'b110000; tick();
    idle();

    // Whilo with no valid lanes is dropped
    mem_whilo = 1'b1; mem_valid = 2'b00; mem_hi = 32'h9; tick();

    // Retire counter wrap
    idle();
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    model.retire = 32'hFFFF_FFFF;
    mem_valid = 2'b01; tick();
    idle(); mem_valid = 2'b11; tick();

    // Bubble counter saturation
    idle(); stop = 6'b010000;
    for (int k = 0; k < 65540; k++) tick();

    // Reset mid-stall, then mid-flush
    stop = 6'b110000; tick();
    rst = 1'b1; tick();
    idle(); mem_valid = 2'b11; mem_wd = {5'd1, 5'd2}; mem_wreg = 2'b11; tick();
    flush = 1'b1; rst = 1'b1; tick();
    idle();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      randomize_mem();
      stop  = STALL_W'($urandom);
      stop[STAGE] = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle();

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_multi.md
MEM_WB_MULTI -- requirements
Module: mem_wb_multi

Interface
REQ-001 Parameter LANES, default 2: number of parallel issue lanes; legal values 1-4.
REQ-002 Parameter DW, default 32: register data width.
REQ-003 Parameter AW, default 5: register address width.
REQ-004 Parameter STALL_W, default 6: width of the stall vector.
REQ-005 Parameter STAGE, default 4: this stage's bit index in the stall vector; STAGE+1 SHALL be less than STALL_W.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 stop  in  STALL_W  pipeline stall vector; stop[STAGE] = this stage stalled, stop[STAGE+1] = downstream stalled.
REQ-009 flush  in  1  discard the in-flight MEM results (exception/redirect).
REQ-010 mem_valid  in  LANES  per-lane instruction-valid from MEM.
REQ-011 mem_wd  in  LANES*AW  per-lane destination register; lane i occupies bits [i*AW +: AW].
REQ-012 mem_wreg  in  LANES  per-lane register-write enable.
REQ-013 mem_wdata  in  LANES*DW  per-lane write data; lane i occupies bits [i*DW +: DW].
REQ-014 mem_whilo, mem_hi, mem_lo  in  1, DW, DW  HI/LO write request and values; the request is shared across lanes.
REQ-015 wb_valid, wb_wd, wb_wreg, wb_wdata  out  LANES, LANES*AW, LANES, LANES*DW  registered copies of the per-lane MEM signals, presented to write-back.
REQ-016 wb_whilo, wb_hi, wb_lo  out  1, DW, DW  registered HI/LO write.
REQ-017 retire_cnt  out  32  count of retired instructions.
REQ-018 bubble_cnt  out  16  count of inserted bubbles.

Function
REQ-019 Every output SHALL be a flop; no combinational path from any input to any output.
REQ-020 Each cycle SHALL select exactly one action, in this priority order:
 - reset
 - flush
 - bubble, when stop[STAGE]=1 and stop[STAGE+1]=0
 - advance, when stop[STAGE]=0
 - hold, when stop[STAGE]=1 and stop[STAGE+1]=1
REQ-021 Advance SHALL capture all MEM inputs into the wb_* outputs, with a latency of 1 cycle.
REQ-022 Advance: for any lane with mem_valid=0, wb_wreg for that lane SHALL be 0, regardless of mem_wreg.
REQ-023 Advance: for any lane with mem_wd=0, wb_wreg for that lane SHALL be 0; register 0 is never written.
REQ-024 Advance, duplicate destination: if lanes i<j are both valid with wreg=1 and the same nonzero wd, lane i's wb_wreg SHALL be 0; the youngest (highest index) lane wins.
REQ-025 Advance: wb_whilo SHALL be mem_whilo AND (OR of mem_valid).
REQ-026 Flush and bubble SHALL each clear the outputs: wb_valid=0, wb_wreg=0, wb_whilo=0, wb_wd=0, wb_wdata=0, wb_hi=0, wb_lo=0.
REQ-027 Hold SHALL leave all wb_* outputs and both counters unchanged.
REQ-028 retire_cnt SHALL increase by popcount(mem_valid) on advance only; it wraps modulo 2^32.
REQ-029 bubble_cnt SHALL increase by 1 on each bubble cycle and saturate at 0xFFFF; flush cycles do not increment it.
REQ-030 flush and stall asserted in the same cycle: flush SHALL win, and no counter changes.
REQ-031 With LANES=1 the behaviour SHALL reduce to a single-lane MEM/WB register with the same stall semantics.

Reset
REQ-032 While rst=1 at a clock edge, every output SHALL be 0, including retire_cnt and bubble_cnt; this overrides all other inputs.
REQ-033 Reset asserted mid-stall or mid-flush SHALL yield the same all-zero state.
REQ-034 On the first edge with rst=0, the normal priority rules SHALL apply.

Verification
REQ-035 Advance (LANES=2):
 - stimulus: stop=0, valid=2'b11, wd={5'd3,5'd4}, wreg=2'b11, wdata={32'hA,32'hB}
 - response: next cycle wb_wd equals the inputs, wb_wreg=2'b11, retire_cnt +2.
REQ-036 Stall sequence:
 - bubble: stop[4]=1, stop[5]=0 -> wb_wreg=0, wb_valid=0, bubble_cnt +1
 - hold: then stop[4]=1, stop[5]=1 with changing inputs -> wb_* frozen across 3 cycles.
REQ-037 Duplicate destination:
 - stimulus: both lanes valid, wreg=1, wd=5'd7, data 32'h11 (lane0) / 32'h22 (lane1)
 - response: wb_wreg=2'b10; lane1 data 32'h22.
REQ-038 Register 0 and invalid lanes:
 - stimulus: lane0 wd=0 with wreg=1; lane1 valid=0 with wreg=1
 - response: wb_wreg=2'b00; retire_cnt +1.
REQ-039 Flush priority and HI/LO:
 - stimulus: flush=1 together with stop[4]=1 and mem_whilo=1
 - response: all outputs cleared; wb_whilo=0; bubble_cnt and retire_cnt unchanged.
REQ-040 Counter limits and reset:
 - preload: retire_cnt=32'hFFFFFFFF via a run, or force in simulation
 - wrap: advance with 1 valid lane -> retire_cnt=0
 - saturation: 65536 bubbles -> bubble_cnt stays 0xFFFF
 - reset: rst=1 mid-run -> all zero next edge.
